// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    localparam int ADD_WIDTH = 8;

    // 2'd3 is unused; the FSM decodes it back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
// Latency: n/a (wires only).
// Backpressure: requester may only raise start while busy and done are both low.
// Ports: start/a/b from the requester; busy/done/sum/carry_out back from the adder.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit full adder built from two half adders and an OR on their carries.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y, cin in; s, cout out.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    logic g0;
    logic g1;

    half_adder u_ha0 (.x(x),   .y(y),   .s(p), .c(g0));
    half_adder u_ha1 (.x(p),   .y(cin), .s(s), .c(g1));

    // The two carries can never both be set, so OR equals XOR here.
    assign cout = g0 | g1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, registered carry.
// Latency: done pulses WIDTH edges after the edge accepting start; next start at WIDTH+2.
// Backpressure: start is only sampled in IDLE; it is never queued.
// Ports: clk, rst_n (sync, active-low), bus (slave side of serial_adder_if).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] acc_next;

    full_adder_bit u_fa (
        .x    (sa[0]),
        .y    (sb[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lines up with the LSB.
    // Written with shifts so it also holds for WIDTH == 1.
    assign acc_next = (acc >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sa            <= '0;
            sb            <= '0;
            acc           <= '0;
            c             <= 1'b0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        c        <= 1'b0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= acc_next;
                    c   <= fa_c;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.sum       <= acc_next;
                        bus.carry_out <= fa_c;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
